wb_gpio_irq_regs: RTL and testbench
===================================

# wb_gpio_irq_regs

Parametrised Wishbone control/status register block for the FazyRV SoC. It replaces the fixed GPIO/SPI register file with the following features:
- configurable GPIO widths;
- input synchronisers;
- per-pin rising/falling edge interrupts with write-1-to-clear pending bits;
- a GPO toggle register;
- a registered, single-wait-state acknowledge.

It sits on the CPU data bus next to the QSPI controller and drives its configuration pins.

## Interface
Parameters:
- GPI_W, 7, general purpose input width, 1..31
- GPO_W, 6, general purpose output width, 1..32
- SYNC_STAGES, 2, flip-flop stages on each gpi_i bit, ≥2
- PRESC_RST, 11, reset value of spi_presc_o, 0..15

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_in  in  1  reset; asynchronous, active-low
- wb_regs_cyc_i  in  1  Wishbone cycle
- wb_regs_stb_i  in  1  Wishbone strobe
- wb_regs_we_i  in  1  write enable
- wb_regs_ack_o  out  1  acknowledge, registered
- wb_regs_adr_i  in  3  word address
- wb_regs_be_i  in  4  byte enables
- wb_regs_dat_i  in  32  write data
- wb_regs_dat_o  out  32  read data, registered
- gpi_i  in  GPI_W  asynchronous general purpose inputs
- gpo_o  out  GPO_W  general purpose outputs
- irq_o  out  1  level interrupt, high while any pending bit is set
- spi_rdy_i  in  1  SPI ready, synchronous to clk_i
- spi_presc_o  out  4  SPI prescaler
- spi_cpol_o  out  1  SPI CPOL
- spi_auto_cs_o  out  1  SPI auto chip select
- spi_size_o  out  2  SPI transfer size in bytes

## Operation
Register map (word address, access, fields). Bits not listed read 0 and ignore writes.
- 0 GPO, RW: [GPO_W-1:0] output value.
- 1 GPI, RO: [GPI_W-1:0] synchronised inputs.
- 2 SPI_CTRL, RW: [3:0] presc, [9] cpol, [10] auto_cs, [17:16] size.
- 3 IRQ_RISE, RW: [GPI_W-1:0] rising-edge enable per pin; [31] spi_rdy rising-edge enable.
- 4 STAT, RO: [0] spi_rdy_i, [1] irq_o.
- 5 IRQ_FALL, RW: [GPI_W-1:0] falling-edge enable per pin.
- 6 IRQ_PEND, RW1C: [GPI_W-1:0] pin pending bits, [31] spi_rdy pending bit; writing 1 clears, writing 0 has no effect.
- 7 GPO_TGL, WO: each 1 bit in [GPO_W-1:0] inverts the corresponding GPO bit; reads 0.

Byte enables:
- Each write affects only the bytes whose be bit is set, for every register including IRQ_PEND and GPO_TGL.
- be = 0000 writes nothing but is still acknowledged.

Edge detection:
- gpi_s is the last synchroniser stage; gpi_p is gpi_s delayed by one cycle.
- rise[i] = gpi_s[i] & ~gpi_p[i]; fall[i] = ~gpi_s[i] & gpi_p[i].
- pend[i] sets when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- pend[31] sets on a 0→1 transition of spi_rdy_i when RISE_EN[31] = 1.
- Clearing an enable does not clear an existing pending bit.
- A set and a W1C of the same bit in the same cycle: set wins, the bit stays 1.
- irq_o = |pend, driven directly from the pending register with no further gating.

Reset values (asynchronous, rst_in = 0):
- All outputs: gpo_o 0, spi_presc_o PRESC_RST, spi_cpol_o 0, spi_auto_cs_o 0, spi_size_o 0, irq_o 0, wb_regs_ack_o 0, wb_regs_dat_o 0.
- Internal state: enables 0, pend 0, synchronisers 0, gpi_p 0, previous spi_rdy 0.
- A high pin after reset produces a rise edge; it is not recorded because enables are 0.
- Reset asserted mid-transfer drops ack immediately; the transfer is lost and the master must retry.

## Timing
- Request = cyc & stb & ~ack_o, sampled at a rising edge.
- At that edge:
  - ack_o goes high for exactly one cycle;
  - dat_o loads the read value of the addressed register, or 0 for writes;
  - a write commits.
- Latency is 1 cycle.
- A back-to-back request is accepted one cycle after ack_o falls, giving at most one transfer every 2 cycles.
- A request seen after cyc drops is never acknowledged and never commits.
- Register outputs (gpo_o, spi_*) change at the commit edge.
- A GPO_TGL write commits together with any GPO pin event in the same cycle; no GPO write is lost.
- gpi_i change to the GPI read value: SYNC_STAGES cycles.
- gpi_i change to pend and irq_o high: SYNC_STAGES+1 cycles.
- spi_rdy_i rise to pend[31]: 1 cycle.
- A W1C commit drops irq_o in the same edge, provided no other bit is pending and no new event occurs in that cycle.

## Test plan
- Reset, then read all 8 addresses: GPO 0, SPI_CTRL 0x0000000B (PRESC_RST = 11), all others 0; ack_o high exactly 1 cycle after each request.
- Write GPO 0x3F with be = 0001, then GPO_TGL 0x05: gpo_o = 0x3A; a write with be = 0000 leaves 0x3A.
- Write SPI_CTRL 0x00030603 with be = 0111: presc 3, cpol 1, auto_cs 1, size 3; a write with be = 0001 and data 0 changes only presc, to 0.
- Write IRQ_RISE 0x1, drive gpi_i[0] 0→1: irq_o rises 3 cycles later (SYNC_STAGES = 2), IRQ_PEND reads 0x1; write 0x1 to IRQ_PEND: irq_o falls at the commit edge.
- Write IRQ_FALL 0x2, hold gpi_i[1] high, then pulse it low for 1 cycle: no pending bit is guaranteed; pulse it low for 3 cycles: pend[1] = 1.
- Write IRQ_RISE 0x80000000, then raise spi_rdy_i in the same cycle that a W1C of bit 31 commits: pend[31] stays 1; assert rst_in mid-request: ack_o and pend drop to 0 asynchronously.

Source files
------------

// File: rtl/wb_gpio_irq_regs.sv
// wb_gpio_irq_regs: Wishbone GPIO/SPI control registers with synchronised, edge-triggered pin interrupts
module wb_gpio_irq_regs #(
  parameter int GPI_W       = 7,
  parameter int GPO_W       = 6,
  parameter int SYNC_STAGES = 2,
  parameter int PRESC_RST   = 11
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             wb_regs_cyc_i,
  input  logic             wb_regs_stb_i,
  input  logic             wb_regs_we_i,
  output logic             wb_regs_ack_o,
  input  logic [2:0]       wb_regs_adr_i,
  input  logic [3:0]       wb_regs_be_i,
  input  logic [31:0]      wb_regs_dat_i,
  output logic [31:0]      wb_regs_dat_o,
  input  logic [GPI_W-1:0] gpi_i,
  output logic [GPO_W-1:0] gpo_o,
  output logic             irq_o,
  input  logic             spi_rdy_i,
  output logic [3:0]       spi_presc_o,
  output logic             spi_cpol_o,
  output logic             spi_auto_cs_o,
  output logic [1:0]       spi_size_o
);
  localparam logic [31:0] PIN_M  = 32'((64'd1 << GPI_W) - 64'd1);
  localparam logic [31:0] RISE_M = PIN_M | 32'h8000_0000;
  logic [GPI_W-1:0] sync_q [SYNC_STAGES];
  logic [GPI_W-1:0] gpi_s, gpi_p, pin_evt;
  logic             rdy_p, req, wr;
  logic [31:0]      be_m, wd, rd, evt, rise_en, fall_en, pend;
  assign req     = wb_regs_cyc_i & wb_regs_stb_i & ~wb_regs_ack_o;
  assign wr      = req & wb_regs_we_i;
  assign be_m    = {{8{wb_regs_be_i[3]}}, {8{wb_regs_be_i[2]}}, {8{wb_regs_be_i[1]}}, {8{wb_regs_be_i[0]}}};
  assign wd      = wb_regs_dat_i & be_m;
  assign gpi_s   = sync_q[SYNC_STAGES-1];
  assign pin_evt = (gpi_s & ~gpi_p & rise_en[GPI_W-1:0]) | (~gpi_s & gpi_p & fall_en[GPI_W-1:0]);
  assign evt     = 32'(pin_evt) | {spi_rdy_i & ~rdy_p & rise_en[31], 31'b0};
  assign irq_o   = |pend;
  always_comb begin
    rd = '0;
    case (wb_regs_adr_i)
      3'd0:    rd = 32'(gpo_o);
      3'd1:    rd = 32'(gpi_s);
      3'd2:    rd = {14'b0, spi_size_o, 5'b0, spi_auto_cs_o, spi_cpol_o, 5'b0, spi_presc_o};
      3'd3:    rd = rise_en;
      3'd4:    rd = {30'b0, irq_o, spi_rdy_i};
      3'd5:    rd = fall_en;
      3'd6:    rd = pend;
      default: rd = '0;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_in)
    if (!rst_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      gpi_p         <= '0;
      rdy_p         <= 1'b0;
      wb_regs_ack_o <= 1'b0;
      wb_regs_dat_o <= '0;
      gpo_o         <= '0;
      spi_presc_o   <= 4'(PRESC_RST);
      spi_cpol_o    <= 1'b0;
      spi_auto_cs_o <= 1'b0;
      spi_size_o    <= '0;
      rise_en       <= '0;
      fall_en       <= '0;
      pend          <= '0;
    end else begin
      sync_q[0] <= gpi_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      gpi_p         <= gpi_s;
      rdy_p         <= spi_rdy_i;
      wb_regs_ack_o <= req;
      if (req) wb_regs_dat_o <= wb_regs_we_i ? '0 : rd;
      if (wr && wb_regs_adr_i == 3'd0) gpo_o <= (gpo_o & ~be_m[GPO_W-1:0]) | wd[GPO_W-1:0];
      if (wr && wb_regs_adr_i == 3'd7) gpo_o <= gpo_o ^ wd[GPO_W-1:0];
      if (wr && wb_regs_adr_i == 3'd2) begin
        spi_presc_o   <= be_m[0]  ? wd[3:0]   : spi_presc_o;
        spi_cpol_o    <= be_m[9]  ? wd[9]     : spi_cpol_o;
        spi_auto_cs_o <= be_m[10] ? wd[10]    : spi_auto_cs_o;
        spi_size_o    <= be_m[16] ? wd[17:16] : spi_size_o;
      end
      if (wr && wb_regs_adr_i == 3'd3) rise_en <= (rise_en & ~be_m) | (wd & RISE_M);
      if (wr && wb_regs_adr_i == 3'd5) fall_en <= (fall_en & ~be_m) | (wd & PIN_M);
      // new events are OR-ed after the clear so a simultaneous set wins
      pend <= (pend & ~((wr && wb_regs_adr_i == 3'd6) ? wd : 32'b0)) | evt;
    end
endmodule

// File: tb/tb_wb_gpio_irq_regs.sv
// tb_wb_gpio_irq_regs: directed and randomized checks of wb_gpio_irq_regs against a register-level model
module tb_wb_gpio_irq_regs;
  localparam int GPI_W = 7, GPO_W = 6, SYNC = 2, PRESC = 11;
  localparam logic [31:0] PIN_M = 32'h0000_007F, RISE_M = 32'h8000_007F, GPO_M = 32'h0000_003F, SPI_M = 32'h0003_060F;
  logic clk = 0, rst_n = 0, cyc = 0, stb = 0, we = 0, spi_rdy = 0;
  logic [2:0] adr = 0;
  logic [3:0] be = 0;
  logic [31:0] dat_i = 0, dat_o;
  logic ack, irq, cpol, auto_cs;
  logic [GPI_W-1:0] gpi = 0;
  logic [GPO_W-1:0] gpo;
  logic [3:0] presc;
  logic [1:0] size;
  int checks = 0, failures = 0;
  logic [31:0] m_gpo, m_spi, m_rise, m_fall, m_pend, m_gpi;
  logic m_rdy;

  wb_gpio_irq_regs #(.GPI_W(GPI_W), .GPO_W(GPO_W), .SYNC_STAGES(SYNC), .PRESC_RST(PRESC)) dut (
    .clk_i(clk), .rst_in(rst_n), .wb_regs_cyc_i(cyc), .wb_regs_stb_i(stb), .wb_regs_we_i(we),
    .wb_regs_ack_o(ack), .wb_regs_adr_i(adr), .wb_regs_be_i(be), .wb_regs_dat_i(dat_i),
    .wb_regs_dat_o(dat_o), .gpi_i(gpi), .gpo_o(gpo), .irq_o(irq), .spi_rdy_i(spi_rdy),
    .spi_presc_o(presc), .spi_cpol_o(cpol), .spi_auto_cs_o(auto_cs), .spi_size_o(size)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] bmask(input logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    case (a)
      3'd0: return m_gpo;
      3'd1: return m_gpi;
      3'd2: return m_spi;
      3'd3: return m_rise;
      3'd4: return {30'b0, |m_pend, m_rdy};
      3'd5: return m_fall;
      3'd6: return m_pend;
      default: return 32'b0;
    endcase
  endfunction

  task automatic bus(input logic w, input logic [2:0] a, input logic [3:0] b, input logic [31:0] d, output logic [31:0] q);
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; be = b; dat_i = d;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL bus_ack adr=%0d got=%b exp=1", a, ack); end
    q = dat_o;
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL bus_ack_width adr=%0d got=%b exp=0", a, ack); end
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] b, input logic [31:0] d);
    logic [31:0] q;
    bus(1'b1, a, b, d, q);
  endtask

  task automatic apply_reset();
    cyc = 0; stb = 0; we = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    m_gpo = 0; m_spi = PRESC; m_rise = 0; m_fall = 0; m_pend = 0;
  endtask

  task automatic test_reset();
    logic [31:0] q, e;
    gpi = 0; spi_rdy = 0;
    apply_reset();
    #1;
    checks++;
    if ({ack, dat_o, irq} !== 34'b0) begin failures++; $display("FAIL reset_bus got=%b/%h/%b exp=0/0/0", ack, dat_o, irq); end
    checks++;
    if ({gpo, presc, cpol, auto_cs, size} !== {6'h0, 4'hB, 1'b0, 1'b0, 2'b0}) begin
      failures++; $display("FAIL reset_outs got gpo=%h presc=%h cpol=%b acs=%b size=%h", gpo, presc, cpol, auto_cs, size);
    end
    for (int a = 0; a < 8; a++) begin
      bus(1'b0, 3'(a), 4'hF, 32'h0, q);
      e = (a == 2) ? 32'h0000_000B : 32'h0;
      checks++;
      if (q !== e) begin failures++; $display("FAIL reset_read adr=%0d got=%h exp=%h", a, q, e); end
    end
  endtask

  task automatic test_gpo();
    logic [31:0] q;
    wr(3'd0, 4'b0001, 32'h3F);
    checks++; if (gpo !== 6'h3F) begin failures++; $display("FAIL gpo_write got=%h exp=3f", gpo); end
    wr(3'd7, 4'hF, 32'h05);
    checks++; if (gpo !== 6'h3A) begin failures++; $display("FAIL gpo_toggle got=%h exp=3a", gpo); end
    wr(3'd0, 4'b0000, 32'h0);
    checks++; if (gpo !== 6'h3A) begin failures++; $display("FAIL gpo_be0 got=%h exp=3a", gpo); end
    wr(3'd7, 4'b0000, 32'hFFFF_FFFF);
    checks++; if (gpo !== 6'h3A) begin failures++; $display("FAIL gpo_tgl_be0 got=%h exp=3a", gpo); end
    bus(1'b0, 3'd0, 4'hF, 32'h0, q);
    checks++; if (q !== 32'h3A) begin failures++; $display("FAIL gpo_read got=%h exp=3a", q); end
    bus(1'b0, 3'd7, 4'hF, 32'h0, q);
    checks++; if (q !== 32'h0) begin failures++; $display("FAIL tgl_read got=%h exp=0", q); end
  endtask

  task automatic test_spi_ctrl();
    logic [31:0] q;
    wr(3'd2, 4'b0111, 32'h0003_0603);
    checks++;
    if ({presc, cpol, auto_cs, size} !== {4'd3, 1'b1, 1'b1, 2'd3}) begin
      failures++; $display("FAIL spi_write got presc=%h cpol=%b acs=%b size=%h", presc, cpol, auto_cs, size);
    end
    wr(3'd2, 4'b0001, 32'h0);
    bus(1'b0, 3'd2, 4'hF, 32'h0, q);
    checks++; if (q !== 32'h0003_0600) begin failures++; $display("FAIL spi_be got=%h exp=00030600", q); end
  endtask

  task automatic test_rise_irq();
    logic [31:0] q;
    wr(3'd3, 4'hF, 32'h1);
    @(negedge clk) gpi[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1; checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rise_early got=%b exp=0", irq); end
    @(posedge clk);
    #1; checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rise_latency got=%b exp=1", irq); end
    bus(1'b0, 3'd6, 4'hF, 32'h0, q);
    checks++; if (q !== 32'h1) begin failures++; $display("FAIL rise_pend got=%h exp=1", q); end
    bus(1'b0, 3'd1, 4'hF, 32'h0, q);
    checks++; if (q !== 32'h1) begin failures++; $display("FAIL gpi_read got=%h exp=1", q); end
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 3'd6; be = 4'hF; dat_i = 32'h1;
    @(posedge clk); #1;
    checks++;
    if ({ack, irq} !== 2'b10) begin failures++; $display("FAIL w1c_edge got ack/irq=%b%b exp=10", ack, irq); end
    cyc = 0; stb = 0; we = 0;
    @(posedge clk);
  endtask

  task automatic test_fall_irq();
    logic [31:0] q;
    wr(3'd5, 4'hF, 32'h2);
    @(negedge clk) gpi[1] = 1'b1;
    repeat (5) @(negedge clk);
    gpi[1] = 1'b0;
    @(negedge clk) gpi[1] = 1'b1;
    repeat (5) @(negedge clk);
    wr(3'd6, 4'hF, 32'hFFFF_FFFF);
    bus(1'b0, 3'd6, 4'hF, 32'h0, q);
    checks++; if (q !== 32'h0) begin failures++; $display("FAIL fall_clear got=%h exp=0", q); end
    @(negedge clk) gpi[1] = 1'b0;
    repeat (3) @(negedge clk);
    gpi[1] = 1'b1;
    repeat (6) @(negedge clk);
    bus(1'b0, 3'd6, 4'hF, 32'h0, q);
    checks++; if (q !== 32'h2) begin failures++; $display("FAIL fall_pend got=%h exp=2", q); end
    wr(3'd5, 4'hF, 32'h0);
    wr(3'd6, 4'b0010, 32'h2);
    bus(1'b0, 3'd6, 4'hF, 32'h0, q);
    checks++; if (q !== 32'h2) begin failures++; $display("FAIL pend_keep got=%h exp=2", q); end
    wr(3'd6, 4'b0001, 32'h2);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL w1c_be got=%b exp=0", irq); end
  endtask

  task automatic test_spi_rdy();
    logic [31:0] q;
    wr(3'd3, 4'hF, 32'h8000_0000);
    @(negedge clk) spi_rdy = 1'b1;
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rdy_latency got=%b exp=1", irq); end
    @(negedge clk) spi_rdy = 1'b0;
    repeat (2) @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 3'd6; be = 4'b1000; dat_i = 32'h8000_0000; spi_rdy = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ack, irq} !== 2'b11) begin failures++; $display("FAIL set_wins got ack/irq=%b%b exp=11", ack, irq); end
    cyc = 0; stb = 0; we = 0;
    @(posedge clk);
    bus(1'b0, 3'd6, 4'hF, 32'h0, q);
    checks++; if (q !== 32'h8000_0000) begin failures++; $display("FAIL set_wins_pend got=%h exp=80000000", q); end
    wr(3'd6, 4'b1000, 32'h8000_0000);
    bus(1'b0, 3'd4, 4'hF, 32'h0, q);
    checks++; if (q !== 32'h1) begin failures++; $display("FAIL stat got=%h exp=1", q); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] acks;
    logic [31:0] first;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 3'd2; be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      acks[i] = ack;
      if (i == 0) first = dat_o;
    end
    cyc = 0; stb = 0;
    checks++; if (acks !== 4'b0101) begin failures++; $display("FAIL b2b_ack got=%b exp=0101", acks); end
    checks++; if (first !== 32'h0003_0600) begin failures++; $display("FAIL b2b_data got=%h exp=00030600", first); end
    @(negedge clk);
    cyc = 0; stb = 1; we = 1; adr = 3'd0; be = 4'hF; dat_i = 32'h15;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ack, gpo} !== {1'b0, 6'h3A}) begin failures++; $display("FAIL no_cyc got ack=%b gpo=%h exp ack=0 gpo=3a", ack, gpo); end
    stb = 0; we = 0;
  endtask

  task automatic test_async_reset();
    @(negedge clk) spi_rdy = 1'b0;
    @(negedge clk) spi_rdy = 1'b1;
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 3'd1; be = 4'hF;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    checks++;
    if ({ack, irq, gpo} !== 8'b0) begin failures++; $display("FAIL async_reset got ack=%b irq=%b gpo=%h exp 0", ack, irq, gpo); end
    cyc = 0; stb = 0;
    @(negedge clk) rst_n = 1;
    repeat (5) @(negedge clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL post_reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_random();
    logic [31:0] q, d, msk, ng;
    logic [2:0] a;
    logic [3:0] b;
    logic nr;
    spi_rdy = 0;
    gpi = GPI_W'($urandom);
    apply_reset();
    repeat (5) @(negedge clk);
    m_gpi = 32'(gpi); m_rdy = 0;
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 3'($urandom_range(0, 7)); b = 4'($urandom_range(0, 15)); d = $urandom;
          if ($urandom_range(0, 1) == 1) d = d & 32'h8000_00FF;
          wr(a, b, d);
          msk = bmask(b);
          case (a)
            3'd0: m_gpo = ((m_gpo & ~msk) | (d & msk)) & GPO_M;
            3'd2: m_spi = ((m_spi & ~msk) | (d & msk)) & SPI_M;
            3'd3: m_rise = ((m_rise & ~msk) | (d & msk)) & RISE_M;
            3'd5: m_fall = ((m_fall & ~msk) | (d & msk)) & PIN_M;
            3'd6: m_pend = m_pend & ~(d & msk);
            3'd7: m_gpo = (m_gpo ^ (d & msk)) & GPO_M;
            default: ;
          endcase
        end
        1: begin
          a = 3'($urandom_range(0, 7));
          bus(1'b0, a, 4'($urandom_range(0, 15)), $urandom, q);
          checks++;
          if (q !== exp_rd(a)) begin failures++; $display("FAIL rand_read it=%0d adr=%0d got=%h exp=%h", it, a, q, exp_rd(a)); end
        end
        2: begin
          ng = $urandom & PIN_M;
          m_pend = m_pend | (((~m_gpi & ng & m_rise) | (m_gpi & ~ng & m_fall)) & PIN_M);
          @(negedge clk) gpi = GPI_W'(ng);
          repeat (SYNC + 3) @(negedge clk);
          m_gpi = ng;
        end
        default: begin
          nr = 1'($urandom_range(0, 1));
          if (!m_rdy && nr && m_rise[31]) m_pend[31] = 1'b1;
          @(negedge clk) spi_rdy = nr;
          repeat (2) @(negedge clk);
          m_rdy = nr;
        end
      endcase
      checks++;
      if (irq !== |m_pend) begin failures++; $display("FAIL rand_irq it=%0d got=%b exp=%b", it, irq, |m_pend); end
      checks++;
      if (32'(gpo) !== m_gpo) begin failures++; $display("FAIL rand_gpo it=%0d got=%h exp=%h", it, gpo, m_gpo); end
      checks++;
      if ({size, auto_cs, cpol, presc} !== {m_spi[17:16], m_spi[10], m_spi[9], m_spi[3:0]}) begin
        failures++; $display("FAIL rand_spi it=%0d got=%b exp_reg=%h", it, {size, auto_cs, cpol, presc}, m_spi);
      end
    end
  endtask

  initial begin
    test_reset();
    test_gpo();
    test_spi_ctrl();
    test_rise_irq();
    test_fall_irq();
    test_spi_rdy();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
